// File: rtl/pcie_tx_rr_arbiter.sv
// Packet-granular round-robin arbiter for one PCIe SS TX AXI-S channel.
// A requester keeps the channel from its first beat through tlast, so TLPs from
// different AFU exercisers never interleave. The master side is a single fully
// registered output stage that streams one beat per clock when unstalled.
module pcie_tx_rr_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               s_tvalid,
  output logic [NUM_REQ-1:0]               s_tready,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_REQ*TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_REQ*TUSER_WIDTH-1:0]   s_tuser,
  input  logic [NUM_REQ-1:0]               s_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [TDATA_WIDTH-1:0]           m_tdata,
  output logic [TDATA_WIDTH/8-1:0]         m_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_tuser,
  output logic                             m_tlast,
  output logic [NUM_REQ-1:0]               grant_oh,
  output logic                             pkt_cnt_ovf
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] rr_sel;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] sel;
  logic             rr_found;
  logic             can_load;
  logic             s_fire;
  logic             sel_last;
  logic [15:0]      pkt_cnt [NUM_REQ];

  // Requester index after i, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  // Round-robin search: first valid requester starting at the pointer, wrapping upward.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    cand     = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && s_tvalid[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // A locked packet keeps its owner; otherwise the round-robin winner is offered the slot.
  assign sel      = (state == LOCKED) ? gidx : rr_sel;
  assign can_load = ~m_tvalid | m_tready;
  assign s_fire   = s_tvalid[sel] & s_tready[sel];
  assign sel_last = s_tlast[sel];

  // Only the selected requester sees ready; nobody is ready while reset is held.
  always_comb begin
    s_tready = '0;
    if (!rst && ((state == LOCKED) || rr_found)) begin
      s_tready[sel] = can_load;
    end
  end

  // Output register: load on a fired beat, hold under backpressure, drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tuser  <= '0;
    end else if (can_load) begin
      m_tvalid <= s_fire;
      if (s_fire) begin
        m_tdata <= s_tdata[sel*TDATA_WIDTH +: TDATA_WIDTH];
        m_tkeep <= s_tkeep[sel*KEEP_W +: KEEP_W];
        m_tuser <= s_tuser[sel*TUSER_WIDTH +: TUSER_WIDTH];
        m_tlast <= sel_last;
      end
    end
  end

  // Grant FSM: lock on a non-final beat, release and advance the pointer on tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      grant_oh <= '0;
    end else if (s_fire) begin
      if (sel_last) begin
        state    <= IDLE;
        grant_oh <= '0;
        ptr      <= next_idx(sel);
      end else begin
        state    <= LOCKED;
        gidx     <= sel;
        grant_oh <= NUM_REQ'(1) << sel;
      end
    end
  end

  // Per-requester packet counters; any wrap raises a sticky flag cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pkt_cnt[i] <= '0;
      end
      pkt_cnt_ovf <= 1'b0;
    end else if (s_fire && sel_last) begin
      pkt_cnt[sel] <= pkt_cnt[sel] + 16'd1;
      if (pkt_cnt[sel] == 16'hFFFF) begin
        pkt_cnt_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tx_rr_arbiter.sv
// Directed bench for pcie_tx_rr_arbiter with three requesters on a 32-bit bus.
// Each requester is a small packet source; beat data encodes {0xA0+id, pkt, beat, 0x5A}.
module tb_pcie_tx_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int UW = 10;
  localparam int KW = DW / 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast;
  logic [N-1:0]    grant_oh;
  logic            pkt_cnt_ovf;

  int len [N];
  int beat [N];
  int pkt [N];
  int pkts_left [N];
  bit hold [N];
  int cnt0;
  int n_checks;
  int n_pass;

  pcie_tx_rr_arbiter #(
    .NUM_REQ    (N),
    .TDATA_WIDTH(DW),
    .TUSER_WIDTH(UW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tuser    (s_tuser),
    .s_tlast    (s_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .grant_oh   (grant_oh),
    .pkt_cnt_ovf(pkt_cnt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic set_src(input int i, input int l, input int p);
    len[i]       = l;
    beat[i]      = 0;
    pkts_left[i] = p;
    hold[i]      = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]           = (pkts_left[i] > 0) && !hold[i];
      s_tlast[i]            = (beat[i] == len[i] - 1);
      s_tdata[i*DW +: DW]   = {8'(8'hA0 + i), 8'(pkt[i]), 8'(beat[i]), 8'h5A};
      s_tkeep[i*KW +: KW]   = KW'(4'hF >> i);
      s_tuser[i*UW +: UW]   = UW'(i * 16 + beat[i]);
    end
  endtask

  task automatic advance(input logic [N-1:0] f);
    for (int i = 0; i < N; i++) begin
      if (f[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]  = pkt[i] + 1;
          pkts_left[i] = pkts_left[i] - 1;
          if (i == 0) cnt0 = cnt0 + 1;
        end else begin
          beat[i] = beat[i] + 1;
        end
      end
    end
  endtask

  // One clock: note what fires at the coming edge, update sources, re-drive, settle.
  task automatic cycle();
    logic [N-1:0] f;
    f = s_tvalid & s_tready;
    @(posedge clk);
    advance(f);
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    set_src(0, 2, 2);
    set_src(1, 2, 1);
    set_src(2, 2, 1);
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_m_tvalid[%0d]: got %b want 0", k, m_tvalid); else n_pass++;
      n_checks++; if (m_tlast !== 1'b0) $display("FAIL rst_m_tlast[%0d]: got %b want 0", k, m_tlast); else n_pass++;
      n_checks++; if (m_tdata !== '0 || m_tkeep !== '0 || m_tuser !== '0)
        $display("FAIL rst_m_payload[%0d]: got %h/%h/%h want 0/0/0", k, m_tdata, m_tkeep, m_tuser); else n_pass++;
      n_checks++; if (grant_oh !== '0) $display("FAIL rst_grant_oh[%0d]: got %b want 000", k, grant_oh); else n_pass++;
      n_checks++; if (s_tready !== '0) $display("FAIL rst_s_tready[%0d]: got %b want 000", k, s_tready); else n_pass++;
      n_checks++; if (pkt_cnt_ovf !== 1'b0) $display("FAIL rst_ovf[%0d]: got %b want 0", k, pkt_cnt_ovf); else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_checks++; if (s_tready !== 3'b001) $display("FAIL first_s_tready: got %b want 001", s_tready); else n_pass++;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL first_m_tvalid: got %b want 0", m_tvalid); else n_pass++;
  endtask

  task automatic test_fairness();
    int exp_src [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    logic [N-1:0] exp_g;
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_g = (k % 2 == 1) ? '0 : N'(1 << exp_src[k]);
      n_checks++; if (m_tvalid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", k, m_tvalid); else n_pass++;
      n_checks++; if (m_tdata[31:24] !== 8'(8'hA0 + exp_src[k]) || m_tdata[15:8] !== 8'(k % 2))
        $display("FAIL rr_data[%0d]: got %h want src %0d beat %0d", k, m_tdata, exp_src[k], k % 2); else n_pass++;
      n_checks++; if (m_tlast !== 1'(k % 2)) $display("FAIL rr_tlast[%0d]: got %b want %0d", k, m_tlast, k % 2); else n_pass++;
      n_checks++; if (grant_oh !== exp_g) $display("FAIL rr_grant[%0d]: got %b want %b", k, grant_oh, exp_g); else n_pass++;
    end
    cycle();
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rr_drain: got %b want 0", m_tvalid); else n_pass++;
  endtask

  task automatic test_lock();
    set_src(0, 4, 1);
    set_src(1, 1, 1);
    hold[1] = 1'b1;
    cycle();
    n_checks++; if (s_tready !== 3'b001) $display("FAIL lock_ready_start: got %b want 001", s_tready); else n_pass++;
    hold[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++; if (s_tready !== 3'b001) $display("FAIL lock_ready[%0d]: got %b want 001", k, s_tready); else n_pass++;
      n_checks++; if (m_tvalid !== 1'b1 || m_tdata[31:24] !== 8'hA0 || m_tdata[15:8] !== 8'(k))
        $display("FAIL lock_data[%0d]: got v=%b %h want req0 beat %0d", k, m_tvalid, m_tdata, k); else n_pass++;
    end
    cycle();
    n_checks++; if (m_tdata[15:8] !== 8'd3 || m_tlast !== 1'b1) $display("FAIL lock_last: got %h last=%b want req0 beat 3 last", m_tdata, m_tlast); else n_pass++;
    n_checks++; if (s_tready !== 3'b010) $display("FAIL lock_handover_ready: got %b want 010", s_tready); else n_pass++;
    cycle();
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata[31:24] !== 8'hA1 || m_tlast !== 1'b1)
      $display("FAIL lock_fifth_beat: got v=%b %h last=%b want req1 last", m_tvalid, m_tdata, m_tlast); else n_pass++;
    cycle();
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL lock_drain: got %b want 0", m_tvalid); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit           exp_v   [7] = '{1, 1, 1, 1, 1, 1, 0};
    int           exp_b   [7] = '{0, 0, 1, 1, 2, 2, 0};
    bit           exp_l   [7] = '{0, 0, 0, 0, 1, 1, 0};
    bit           rdy     [7] = '{0, 1, 0, 1, 0, 1, 1};
    logic [N-1:0] exp_r   [7] = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
    m_tready = 1'b1;
    set_src(1, 3, 1);
    cycle();
    n_checks++; if (s_tready !== 3'b010) $display("FAIL bp_ready_start: got %b want 010", s_tready); else n_pass++;
    for (int k = 0; k < 7; k++) begin
      cycle();
      n_checks++; if (m_tvalid !== 1'(exp_v[k])) $display("FAIL bp_valid[%0d]: got %b want %0d", k, m_tvalid, exp_v[k]); else n_pass++;
      if (exp_v[k]) begin
        n_checks++; if (m_tdata[31:24] !== 8'hA1 || m_tdata[15:8] !== 8'(exp_b[k]) || m_tlast !== 1'(exp_l[k]))
          $display("FAIL bp_beat[%0d]: got %h last=%b want req1 beat %0d last %0d", k, m_tdata, m_tlast, exp_b[k], exp_l[k]); else n_pass++;
      end
      if (k == 4) begin
        n_checks++; if (m_tkeep !== 4'h7 || m_tuser !== 10'd18)
          $display("FAIL bp_keep_user: got %h/%0d want 7/18", m_tkeep, m_tuser); else n_pass++;
      end
      m_tready = rdy[k];
      #1;
      n_checks++; if (s_tready !== exp_r[k]) $display("FAIL bp_s_tready[%0d]: got %b want %b", k, s_tready, exp_r[k]); else n_pass++;
    end
  endtask

  task automatic test_single_beat();
    int exp_src [4] = '{2, 0, 2, 0};
    set_src(0, 1, 1);
    cycle();
    cycle();
    set_src(0, 1, 2);
    set_src(2, 1, 2);
    cycle();
    n_checks++; if (s_tready !== 3'b100) $display("FAIL sb_ready_ptr1: got %b want 100", s_tready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++; if (m_tvalid !== 1'b1 || m_tdata[31:24] !== 8'(8'hA0 + exp_src[k]) || m_tlast !== 1'b1)
        $display("FAIL sb_order[%0d]: got v=%b %h last=%b want src %0d", k, m_tvalid, m_tdata, m_tlast, exp_src[k]); else n_pass++;
      n_checks++; if (grant_oh !== '0) $display("FAIL sb_grant[%0d]: got %b want 000", k, grant_oh); else n_pass++;
    end
    cycle();
  endtask

  task automatic test_counter_wrap();
    set_src(0, 1, 65535 - cnt0);
    for (int k = 0; k < 70000 && pkts_left[0] > 0; k++) cycle();
    n_checks++; if (pkts_left[0] != 0) $display("FAIL ovf_budget: %0d packets still pending, want 0", pkts_left[0]); else n_pass++;
    n_checks++; if (pkt_cnt_ovf !== 1'b0) $display("FAIL ovf_before_wrap: got %b want 0", pkt_cnt_ovf); else n_pass++;
    set_src(0, 1, 1);
    cycle();
    cycle();
    n_checks++; if (pkt_cnt_ovf !== 1'b1) $display("FAIL ovf_on_wrap: got %b want 1", pkt_cnt_ovf); else n_pass++;
    set_src(0, 1, 1);
    cycle();
    cycle();
    n_checks++; if (pkt_cnt_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", pkt_cnt_ovf); else n_pass++;
    cycle();
  endtask

  task automatic test_reset_mid_packet();
    set_src(1, 1, 1);
    cycle();
    cycle();
    set_src(1, 4, 1);
    cycle();
    n_checks++; if (s_tready !== 3'b010) $display("FAIL rm_ready_start: got %b want 010", s_tready); else n_pass++;
    cycle();
    n_checks++; if (grant_oh !== 3'b010 || m_tdata[31:24] !== 8'hA1)
      $display("FAIL rm_locked: got grant %b data %h want 010 req1", grant_oh, m_tdata); else n_pass++;
    rst = 1'b1;
    cycle();
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rm_valid_dropped: got %b want 0", m_tvalid); else n_pass++;
    n_checks++; if (grant_oh !== '0) $display("FAIL rm_grant_cleared: got %b want 000", grant_oh); else n_pass++;
    n_checks++; if (pkt_cnt_ovf !== 1'b0) $display("FAIL rm_ovf_cleared: got %b want 0", pkt_cnt_ovf); else n_pass++;
    rst = 1'b0;
    set_src(1, 1, 1);
    set_src(2, 1, 1);
    drive();
    #1;
    n_checks++; if (s_tready !== 3'b010) $display("FAIL rm_ptr0_ready: got %b want 010", s_tready); else n_pass++;
    cycle();
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata[31:24] !== 8'hA1) $display("FAIL rm_first: got v=%b %h want req1", m_tvalid, m_tdata); else n_pass++;
    cycle();
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata[31:24] !== 8'hA2) $display("FAIL rm_second: got v=%b %h want req2", m_tvalid, m_tdata); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cnt0     = 0;
    rst      = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    for (int i = 0; i < N; i++) begin
      pkt[i] = 0;
      set_src(i, 1, 0);
    end
    test_reset();
    test_fairness();
    test_lock();
    test_backpressure();
    test_single_beat();
    test_counter_wrap();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
